// File: rtl/clock_step_ctrl_if.sv
// Board-side signal bundle of the processor clock controller: mode and step
// inputs from switches/keys, divided clock, enable strobe and LEDs back out.
interface clock_step_ctrl_if #(
    parameter int LED_W = 4
);
    logic [1:0]       mode;
    logic             step_key;
    logic             divclock;
    logic             clk_en;
    logic [LED_W-1:0] LEDR;

    modport master (
        output mode,
        output step_key,
        input  divclock,
        input  clk_en,
        input  LEDR
    );

    modport slave (
        input  mode,
        input  step_key,
        output divclock,
        output clk_en,
        output LEDR
    );
endinterface

// File: rtl/clock_step_ctrl.sv
// Processor clock generator: fast/slow divided clock, halt, and debounced
// push-button single-step, with a clk_en strobe on every divclock rise.
module clock_step_ctrl #(
    parameter int CNT_W      = 28,
    parameter int FAST_HALF  = 32,
    parameter int SLOW_HALF  = 8388608,
    parameter int DEB_CYCLES = 1000000,
    parameter int LED_W      = 4
) (
    input  logic               CLOCK_50,
    input  logic               Key,
    clock_step_ctrl_if.slave   bus
);

    localparam int DEB_W = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_HALF - 1);
    localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_HALF - 1);
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_FAST = 2'b00,
        MODE_SLOW = 2'b01,
        MODE_HALT = 2'b10,
        MODE_STEP = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW
    } step_state_t;

    logic [1:0]       r_mode_s1;
    mode_t            r_mode;
    mode_t            r_mode_prev;
    logic             r_step_s1;
    logic             r_step_s2;
    logic [DEB_W-1:0] r_deb_cnt;
    logic             r_step_stable;
    logic             r_press;

    step_state_t      r_state;
    step_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] w_hcnt_nxt;
    logic             r_divclk;
    logic             w_div_nxt;
    logic             r_clk_en;
    logic             w_step_acc;
    logic [CNT_W-1:0] r_step_cnt;
    logic [CNT_W-1:0] r_hb;
    logic [LED_W-1:0] r_led;

    logic             w_run;
    logic             w_prev_run;
    logic             w_mode_chg;
    logic [CNT_W-1:0] w_half_last;

    assign w_run       = (r_mode == MODE_FAST) || (r_mode == MODE_SLOW);
    assign w_prev_run  = (r_mode_prev == MODE_FAST) || (r_mode_prev == MODE_SLOW);
    assign w_mode_chg  = (r_mode != r_mode_prev);
    assign w_half_last = (r_mode == MODE_SLOW) ? SLOW_LAST : FAST_LAST;

    // Synchronisers and step-key debouncer; r_press marks the stable 1->0 edge.
    always_ff @(posedge CLOCK_50 or negedge Key) begin
        if (!Key) begin
            r_mode_s1     <= 2'b00;
            r_mode        <= MODE_FAST;
            r_mode_prev   <= MODE_FAST;
            r_step_s1     <= 1'b1;
            r_step_s2     <= 1'b1;
            r_deb_cnt     <= '0;
            r_step_stable <= 1'b1;
            r_press       <= 1'b0;
        end else begin
            r_mode_s1   <= bus.mode;
            r_mode      <= mode_t'(r_mode_s1);
            r_mode_prev <= r_mode;
            r_step_s1   <= bus.step_key;
            r_step_s2   <= r_step_s1;
            r_press     <= 1'b0;
            if (r_step_s2 == r_step_stable) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == DEB_LAST) begin
                r_deb_cnt     <= '0;
                r_step_stable <= r_step_s2;
                r_press       <= ~r_step_s2;
            end else begin
                r_deb_cnt <= r_deb_cnt + DEB_W'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Key) begin
        if (!Key) begin
            r_state    <= ST_IDLE;
            r_hcnt     <= '0;
            r_divclk   <= 1'b0;
            r_clk_en   <= 1'b0;
            r_step_cnt <= '0;
            r_hb       <= '0;
            r_led      <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_hcnt   <= w_hcnt_nxt;
            r_divclk <= w_div_nxt;
            r_clk_en <= w_div_nxt & ~r_divclk;
            r_hb     <= r_hb + CNT_W'(1);
            if (w_step_acc) begin
                r_step_cnt <= r_step_cnt + CNT_W'(1);
            end
            r_led <= w_run ? r_hb[CNT_W-1 -: LED_W] : r_step_cnt[LED_W-1:0];
        end
    end

    // A mode change only keeps the divclock level between two run modes;
    // anything touching halt/step drops it and abandons a step pulse.
    always_comb begin
        w_state_nxt = r_state;
        w_hcnt_nxt  = r_hcnt;
        w_div_nxt   = r_divclk;
        w_step_acc  = 1'b0;
        if (w_mode_chg) begin
            w_hcnt_nxt  = '0;
            w_state_nxt = ST_IDLE;
            if (!(w_run && w_prev_run)) begin
                w_div_nxt = 1'b0;
            end
        end else begin
            case (r_mode)
                MODE_FAST, MODE_SLOW: begin
                    w_state_nxt = ST_IDLE;
                    if (r_hcnt == w_half_last) begin
                        w_hcnt_nxt = '0;
                        w_div_nxt  = ~r_divclk;
                    end else begin
                        w_hcnt_nxt = r_hcnt + CNT_W'(1);
                    end
                end
                MODE_HALT: begin
                    w_state_nxt = ST_IDLE;
                    w_hcnt_nxt  = '0;
                    w_div_nxt   = 1'b0;
                end
                default: begin
                    case (r_state)
                        ST_IDLE: begin
                            w_hcnt_nxt = '0;
                            w_div_nxt  = 1'b0;
                            if (r_press) begin
                                w_state_nxt = ST_HIGH;
                                w_div_nxt   = 1'b1;
                                w_step_acc  = 1'b1;
                            end
                        end
                        ST_HIGH: begin
                            if (r_hcnt == FAST_LAST) begin
                                w_hcnt_nxt  = '0;
                                w_div_nxt   = 1'b0;
                                w_state_nxt = ST_LOW;
                            end else begin
                                w_hcnt_nxt = r_hcnt + CNT_W'(1);
                            end
                        end
                        ST_LOW: begin
                            w_div_nxt = 1'b0;
                            if (r_hcnt == FAST_LAST) begin
                                w_hcnt_nxt  = '0;
                                w_state_nxt = ST_IDLE;
                            end else begin
                                w_hcnt_nxt = r_hcnt + CNT_W'(1);
                            end
                        end
                        default: begin
                            w_state_nxt = ST_IDLE;
                            w_hcnt_nxt  = '0;
                            w_div_nxt   = 1'b0;
                        end
                    endcase
                end
            endcase
        end
    end

    assign bus.divclock = r_divclk;
    assign bus.clk_en   = r_clk_en;
    assign bus.LEDR     = r_led;

endmodule

// File: tb/tb_clock_step_ctrl.sv
// Directed bench for clock_step_ctrl: segment table for run/step waveforms,
// hand sequences for bounce, halt, async reset and step-counter wrap.
module tb_clock_step_ctrl;

    localparam int CNT_W      = 8;
    localparam int FAST_HALF  = 2;
    localparam int SLOW_HALF  = 8;
    localparam int DEB_CYCLES = 4;
    localparam int LED_W      = 8;

    localparam int LNONE  = 0;
    localparam int LHB    = 1;
    localparam int LCONST = 2;

    typedef struct {
        logic [1:0] mode;
        logic       step_key;
        int         n;
        logic       div;
        logic       en_first;
        int         led_chk;
        logic [7:0] led;
    } seg_t;

    logic CLOCK_50 = 1'b0;
    logic Key;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    seg_t segs[18];

    always #5 CLOCK_50 = ~CLOCK_50;

    clock_step_ctrl_if #(.LED_W(LED_W)) bus ();

    clock_step_ctrl #(
        .CNT_W      (CNT_W),
        .FAST_HALF  (FAST_HALF),
        .SLOW_HALF  (SLOW_HALF),
        .DEB_CYCLES (DEB_CYCLES),
        .LED_W      (LED_W)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .Key      (Key),
        .bus      (bus)
    );

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic seg_t mk(input logic [1:0] m, input logic k, input int n,
                                input logic d, input logic e, input int lc, input logic [7:0] l);
        seg_t s;
        s.mode = m; s.step_key = k; s.n = n; s.div = d; s.en_first = e;
        s.led_chk = lc; s.led = l;
        return s;
    endfunction

    task automatic do_step();
        bus.step_key = 1'b0;
        repeat (12) tick();
        bus.step_key = 1'b1;
        repeat (10) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rises, highs, ens, k;
        logic prev, found, key;
        logic [7:0] hb_exp;
        logic [5:0] dexp, eexp;

        // Edge-by-edge after reset release: fast run, switch to slow while high,
        // then into step mode and one clean press held for 10 cycles.
        segs[0]  = mk(2'b00, 1'b1, 1, 1'b0, 1'b0, LHB,    8'h00);
        segs[1]  = mk(2'b00, 1'b1, 2, 1'b1, 1'b1, LHB,    8'h00);
        segs[2]  = mk(2'b00, 1'b1, 2, 1'b0, 1'b0, LHB,    8'h00);
        segs[3]  = mk(2'b00, 1'b1, 2, 1'b1, 1'b1, LHB,    8'h00);
        segs[4]  = mk(2'b00, 1'b1, 1, 1'b0, 1'b0, LHB,    8'h00);
        segs[5]  = mk(2'b01, 1'b1, 1, 1'b0, 1'b0, LHB,    8'h00);
        segs[6]  = mk(2'b01, 1'b1, 1, 1'b1, 1'b1, LHB,    8'h00);
        segs[7]  = mk(2'b01, 1'b1, 8, 1'b1, 1'b0, LHB,    8'h00);
        segs[8]  = mk(2'b01, 1'b1, 8, 1'b0, 1'b0, LHB,    8'h00);
        segs[9]  = mk(2'b01, 1'b1, 8, 1'b1, 1'b1, LHB,    8'h00);
        segs[10] = mk(2'b01, 1'b1, 8, 1'b0, 1'b0, LHB,    8'h00);
        segs[11] = mk(2'b01, 1'b1, 1, 1'b1, 1'b1, LHB,    8'h00);
        segs[12] = mk(2'b11, 1'b1, 2, 1'b1, 1'b0, LHB,    8'h00);
        segs[13] = mk(2'b11, 1'b1, 4, 1'b0, 1'b0, LCONST, 8'h00);
        segs[14] = mk(2'b11, 1'b0, 6, 1'b0, 1'b0, LCONST, 8'h00);
        segs[15] = mk(2'b11, 1'b0, 2, 1'b1, 1'b1, LNONE,  8'h00);
        segs[16] = mk(2'b11, 1'b0, 2, 1'b0, 1'b0, LCONST, 8'h01);
        segs[17] = mk(2'b11, 1'b1, 8, 1'b0, 1'b0, LCONST, 8'h01);

        Key = 1'b0;
        bus.mode = 2'b00;
        bus.step_key = 1'b1;
        repeat (3) tick();
        chk("rst_divclock", bus.divclock, 0);
        chk("rst_clk_en",   bus.clk_en,   0);
        chk("rst_ledr",     bus.LEDR,     0);

        Key = 1'b1;
        cyc = 0;
        for (int s = 0; s < 18; s++) begin
            bus.mode     = segs[s].mode;
            bus.step_key = segs[s].step_key;
            for (int j = 0; j < segs[s].n; j++) begin
                tick();
                chk($sformatf("seg%0d_divclock", s), bus.divclock, segs[s].div);
                chk($sformatf("seg%0d_clk_en", s), bus.clk_en,
                    (j == 0) ? segs[s].en_first : 1'b0);
                if (segs[s].led_chk == LHB) begin
                    hb_exp = 8'(cyc - 1);
                    chk($sformatf("seg%0d_ledr_hb", s), bus.LEDR, hb_exp);
                end else if (segs[s].led_chk == LCONST) begin
                    chk($sformatf("seg%0d_ledr", s), bus.LEDR, segs[s].led);
                end
            end
        end

        // Bouncing press, then a short re-press glitch while the pulse is busy.
        rises = 0; highs = 0; ens = 0; prev = bus.divclock;
        for (int i = 0; i < 36; i++) begin
            if (i < 6)       key = (i % 2 == 1);
            else if (i < 11) key = 1'b0;
            else if (i < 13) key = 1'b1;
            else if (i < 26) key = 1'b0;
            else             key = 1'b1;
            bus.step_key = key;
            tick();
            if (bus.divclock && !prev) rises++;
            if (bus.divclock) highs++;
            if (bus.clk_en) ens++;
            prev = bus.divclock;
        end
        chk("bounce_rises",     rises, 1);
        chk("bounce_high_cyc",  highs, FAST_HALF);
        chk("bounce_clk_en",    ens,   1);
        chk("bounce_step_cnt",  bus.LEDR, 8'h02);

        // Run fast, then halt just after a rise: high phase cut to one cycle.
        bus.mode = 2'b00;
        repeat (4) tick();
        k = 0; found = 1'b0; prev = bus.divclock;
        while (k < 20 && !found) begin
            tick();
            k++;
            if (prev && !bus.divclock) found = 1'b1;
            prev = bus.divclock;
        end
        chk("halt_fall_seen", found, 1);
        bus.mode = 2'b10;
        tick();
        tick();
        chk("halt_pre_rise_div", bus.divclock, 1);
        chk("halt_pre_rise_en",  bus.clk_en,   1);
        tick();
        chk("halt_forced_div", bus.divclock, 0);
        chk("halt_forced_en",  bus.clk_en,   0);
        rises = 0; ens = 0;
        for (int i = 0; i < 32; i++) begin
            bus.step_key = ((i % 16) < 8) ? 1'b0 : 1'b1;
            tick();
            if (bus.divclock) rises++;
            if (bus.clk_en) ens++;
        end
        chk("halt_div_high_cyc", rises, 0);
        chk("halt_clk_en_cnt",   ens,   0);
        chk("halt_step_cnt",     bus.LEDR, 8'h02);

        // Async reset in the middle of a step pulse.
        bus.step_key = 1'b1;
        bus.mode = 2'b11;
        repeat (8) tick();
        bus.step_key = 1'b0;
        k = 0; found = 1'b0;
        while (k < 30 && !found) begin
            tick();
            k++;
            if (bus.divclock) found = 1'b1;
        end
        chk("rst_mid_pulse_seen", found, 1);
        Key = 1'b0;
        #1;
        chk("rst_async_div",  bus.divclock, 0);
        chk("rst_async_en",   bus.clk_en,   0);
        chk("rst_async_ledr", bus.LEDR,     0);
        bus.mode = 2'b00;
        bus.step_key = 1'b1;
        tick();
        tick();
        Key = 1'b1;
        cyc = 0;
        dexp = 6'b100110;
        eexp = 6'b100010;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("resume_div_e%0d", i + 1), bus.divclock, dexp[i]);
            chk($sformatf("resume_en_e%0d", i + 1),  bus.clk_en,   eexp[i]);
        end

        // step_cnt wrap after 256 accepted steps.
        bus.mode = 2'b11;
        repeat (6) tick();
        chk("wrap_start_cnt", bus.LEDR, 8'h00);
        for (int i = 0; i < 255; i++) do_step();
        chk("wrap_cnt_255", bus.LEDR, 8'hFF);
        do_step();
        chk("wrap_cnt_256", bus.LEDR, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
